// File: rtl/program_loader.sv
// Boot loader: streams a program image into CPU memory,
// checks length/bounds/checksum, then releases the CPU at entry_pc.
module program_loader #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] entry_pc,
  input  logic [DATA_W-1:0] expected_sum,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] cpu_start_pc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    FAULT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] sum_q;

  logic              hs;
  logic              can_start;
  logic              bad_desc;
  logic              last_word;
  logic              sum_ok;
  logic [ADDR_W+1:0] desc_end;

  assign in_ready  = (state == LOAD);
  assign busy      = (state == LOAD) | (state == CHECK);
  assign done      = (state == RUN);
  assign error     = (state == FAULT);
  assign hs        = in_valid & in_ready;
  assign can_start = load_start &
                     ((state == IDLE) | (state == RUN) |
                      (state == FAULT));
  // Widened so base+len can never wrap before the bounds compare.
  assign desc_end  = {2'b00, load_base} + {1'b0, load_len};
  assign bad_desc  = (load_len == '0) |
                     (desc_end > (ADDR_W+2)'(MEM_DEPTH));
  assign last_word = (word_count + (ADDR_W+1)'(1)) == len_q;
  assign sum_ok    = (sum_q == exp_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RUN, FAULT: begin
        if (load_start) state_nx = bad_desc ? FAULT : LOAD;
      end
      LOAD: begin
        if (hs && last_word) state_nx = CHECK;
      end
      CHECK: begin
        state_nx = sum_ok ? RUN : FAULT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Descriptor latch, write port, running sum and CPU control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q       <= '0;
      len_q        <= '0;
      exp_q        <= '0;
      sum_q        <= '0;
      word_count   <= '0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst_n    <= 1'b0;
      cpu_start_pc <= '0;
    end else begin
      mem_wren <= hs;
      if (can_start) begin
        base_q       <= load_base;
        len_q        <= load_len;
        exp_q        <= expected_sum;
        cpu_start_pc <= entry_pc;
        sum_q        <= '0;
        word_count   <= '0;
        cpu_rst_n    <= 1'b0;
      end else if (state == CHECK && sum_ok) begin
        cpu_rst_n <= 1'b1;
      end
      if (hs) begin
        mem_addr   <= base_q + word_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        word_count <= word_count + (ADDR_W+1)'(1);
        sum_q      <= sum_q + in_data;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, stalls, checksum,
// bounds, reload while running and reset mid-load.
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [10:0] load_base;
  logic [11:0] load_len;
  logic [10:0] entry_pc;
  logic [31:0] expected_sum;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_wren;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic [10:0] cpu_start_pc;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] word_count;

  int tests;
  int fails;
  int wr_count;

  program_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_base    (load_base),
    .load_len     (load_len),
    .entry_pc     (entry_pc),
    .expected_sum (expected_sum),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .cpu_start_pc (cpu_start_pc),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count bus writes mid-cycle.
  always @(negedge clk) if (mem_wren === 1'b1) wr_count++;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] b,
                             input logic [11:0] l,
                             input logic [10:0] e,
                             input logic [31:0] s);
    load_base    = b;
    load_len     = l;
    entry_pc     = e;
    expected_sum = s;
    load_start   = 1'b1;
    cyc();
    load_start   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) cyc();
    tests++;
    if ({mem_wren, mem_addr, mem_wdata, cpu_rst_n, cpu_start_pc,
         in_ready, busy, done, error, word_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got wren=%b addr=%h data=%h crst=%b pc=%h rdy=%b busy=%b done=%b err=%b wc=%0d required all zero",
               mem_wren, mem_addr, mem_wdata, cpu_rst_n, cpu_start_pc,
               in_ready, busy, done, error, word_count);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic;
    int w0;
    w0 = wr_count;
    pulse_start(11'h0, 12'd4, 11'h0, 32'h0000000A);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL basic_enter_load got busy=%b rdy=%b crst=%b required 1 1 0",
               busy, in_ready, cpu_rst_n);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      cyc();
      tests++;
      if (mem_wren !== 1'b1 || mem_addr !== 11'(i) ||
          mem_wdata !== 32'(i + 1)) begin
        fails++;
        $display("FAIL basic_write%0d got wren=%b addr=%h data=%h required 1 %h %h",
                 i, mem_wren, mem_addr, mem_wdata, i, i + 1);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 ||
        word_count !== 12'd4) begin
      fails++;
      $display("FAIL basic_check_state got busy=%b rdy=%b done=%b wc=%0d required 1 0 0 4",
               busy, in_ready, done, word_count);
    end
    cyc();
    tests++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || cpu_start_pc !== 11'h0 ||
        mem_wren !== 1'b0 || wr_count - w0 !== 4) begin
      fails++;
      $display("FAIL basic_run got done=%b crst=%b pc=%h wren=%b writes=%0d required 1 1 0 0 4",
               done, cpu_rst_n, cpu_start_pc, mem_wren, wr_count - w0);
    end
  endtask

  task automatic test_reload;
    pulse_start(11'h8, 12'd1, 11'h8, 32'h00000055);
    tests++;
    if (cpu_rst_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL reload_drop got crst=%b busy=%b done=%b required 0 1 0",
               cpu_rst_n, busy, done);
    end
    in_valid = 1'b1;
    in_data  = 32'h55;
    cyc();
    in_valid = 1'b0;
    tests++;
    if (mem_wren !== 1'b1 || mem_addr !== 11'h8 || mem_wdata !== 32'h55) begin
      fails++;
      $display("FAIL reload_write got wren=%b addr=%h data=%h required 1 008 00000055",
               mem_wren, mem_addr, mem_wdata);
    end
    cyc();
    tests++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || cpu_start_pc !== 11'h8) begin
      fails++;
      $display("FAIL reload_run got done=%b crst=%b pc=%h required 1 1 008",
               done, cpu_rst_n, cpu_start_pc);
    end
  endtask

  task automatic test_offset_stall;
    logic [31:0] w [3];
    logic [31:0] s;
    w[0] = 32'hE3A00001;
    w[1] = 32'hE3A01002;
    w[2] = 32'hE0802001;
    s = w[0] + w[1] + w[2];
    pulse_start(11'h100, 12'd3, 11'h100, s);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      cyc();
      in_valid = 1'b0;
      tests++;
      if (mem_wren !== 1'b1 || mem_addr !== 11'(11'h100 + i) ||
          mem_wdata !== w[i]) begin
        fails++;
        $display("FAIL offset_write%0d got wren=%b addr=%h data=%h required 1 %h %h",
                 i, mem_wren, mem_addr, mem_wdata, 11'h100 + i, w[i]);
      end
      if (i < 2) begin
        for (int k = 0; k < 2; k++) begin
          cyc();
          tests++;
          if (mem_wren !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL offset_stall%0d_%0d got wren=%b rdy=%b required 0 1",
                     i, k, mem_wren, in_ready);
          end
        end
      end
    end
    cyc();
    tests++;
    if (done !== 1'b1 || cpu_rst_n !== 1'b1 || cpu_start_pc !== 11'h100) begin
      fails++;
      $display("FAIL offset_run got done=%b crst=%b pc=%h required 1 1 100",
               done, cpu_rst_n, cpu_start_pc);
    end
  endtask

  task automatic test_checksum;
    int w0;
    w0 = wr_count;
    pulse_start(11'h0, 12'd4, 11'h0, 32'h0000000B);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    tests++;
    if (error !== 1'b1 || cpu_rst_n !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL csum_fault got err=%b crst=%b done=%b required 1 0 0",
               error, cpu_rst_n, done);
    end
    in_valid = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    tests++;
    if (wr_count - w0 !== 4 || error !== 1'b1 || cpu_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL csum_hold got writes=%0d err=%b crst=%b required 4 1 0",
               wr_count - w0, error, cpu_rst_n);
    end
  endtask

  task automatic test_bounds;
    int w0;
    w0 = wr_count;
    pulse_start(11'h7FE, 12'd3, 11'h0, 32'h0);
    in_valid = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    tests++;
    if (error !== 1'b1 || busy !== 1'b0 || wr_count - w0 !== 0) begin
      fails++;
      $display("FAIL bounds_over got err=%b busy=%b writes=%0d required 1 0 0",
               error, busy, wr_count - w0);
    end
    w0 = wr_count;
    pulse_start(11'h0, 12'd2048, 11'h7FF, 32'h001FFC00);
    tests++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL bounds_full_accept got busy=%b err=%b required 1 0",
               busy, error);
    end
    for (int i = 0; i < 2048; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      cyc();
    end
    in_valid = 1'b0;
    tests++;
    if (mem_addr !== 11'h7FF || mem_wdata !== 32'h7FF) begin
      fails++;
      $display("FAIL bounds_full_last got addr=%h data=%h required 7ff 000007ff",
               mem_addr, mem_wdata);
    end
    cyc();
    tests++;
    if (done !== 1'b1 || cpu_start_pc !== 11'h7FF ||
        wr_count - w0 !== 2048) begin
      fails++;
      $display("FAIL bounds_full_run got done=%b pc=%h writes=%0d required 1 7ff 2048",
               done, cpu_start_pc, wr_count - w0);
    end
    pulse_start(11'h0, 12'd0, 11'h0, 32'h0);
    tests++;
    if (error !== 1'b1 || cpu_rst_n !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bounds_len0 got err=%b crst=%b busy=%b required 1 0 0",
               error, cpu_rst_n, busy);
    end
  endtask

  task automatic test_reset_midload;
    int w0;
    w0 = wr_count;
    pulse_start(11'h20, 12'd4, 11'h20, 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'(i + 7);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    tests++;
    if ({mem_wren, mem_addr, mem_wdata, cpu_rst_n, cpu_start_pc,
         in_ready, busy, done, error, word_count} !== '0) begin
      fails++;
      $display("FAIL midload_reset got wren=%b addr=%h data=%h crst=%b pc=%h rdy=%b busy=%b done=%b err=%b wc=%0d required all zero",
               mem_wren, mem_addr, mem_wdata, cpu_rst_n, cpu_start_pc,
               in_ready, busy, done, error, word_count);
    end
    rst_n = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    tests++;
    if (wr_count - w0 !== 2 || in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL midload_after got writes=%0d rdy=%b busy=%b done=%b err=%b required 2 0 0 0 0",
               wr_count - w0, in_ready, busy, done, error);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    wr_count     = 0;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    load_base    = '0;
    load_len     = '0;
    entry_pc     = '0;
    expected_sum = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    test_reset();
    test_basic();
    test_reload();
    test_offset_stall();
    test_checksum();
    test_bounds();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
